stream_downsizer: RTL and testbench

//   Width down-converter on the valid/ready stream, sitting directly downstream of the

---
 rtl/stream_downsizer.sv | 118 +++++++++++
 tb/tb_stream_downsizer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsizer.sv
// Wide-to-narrow valid/ready stream converter: one IN_WIDTH word becomes RATIO beats, LSB slice first.
// Optional downstream_last output is enabled by defining STREAM_DOWNSIZER_LAST_EN.
module stream_downsizer #(
    parameter int unsigned IN_WIDTH = 32,
    parameter int unsigned RATIO    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         upstream_vld,
    output logic                         upstream_rdy,
    input  logic [IN_WIDTH-1:0]          upstream_data,
    output logic                         downstream_vld,
    input  logic                         downstream_rdy,
    output logic [IN_WIDTH/RATIO-1:0]    downstream_data
`ifdef STREAM_DOWNSIZER_LAST_EN
    ,
    output logic                         downstream_last
`endif
);

    localparam int unsigned OUT_WIDTH = IN_WIDTH / RATIO;
    localparam int unsigned CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned LAST_CNT  = RATIO - 1;

    generate
        if ((RATIO < 1) || ((IN_WIDTH % RATIO) != 0)) begin : g_bad_params
            $error("stream_downsizer: IN_WIDTH must be a multiple of RATIO and RATIO >= 1");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]    hold_q, hold_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   last_beat;
    logic                   push;
    logic                   pop;
`ifdef STREAM_DOWNSIZER_LAST_EN
    logic                   last_q, last_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
`ifdef STREAM_DOWNSIZER_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
`ifdef STREAM_DOWNSIZER_LAST_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next-state logic; the beat register is preloaded with the slice selected by the next count
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        last_beat    = (cnt_q == CNT_W'(LAST_CNT));
        upstream_rdy = (state_q == EMPTY) |
                       ((state_q == SEND) & last_beat & downstream_rdy);
        push         = upstream_vld & upstream_rdy;
        pop          = (state_q == SEND) & downstream_rdy;

        case (state_q)
            EMPTY: begin
                if (push) begin
                    hold_d  = upstream_data;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (pop) begin
                    if (!last_beat) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (push) begin
                        hold_d = upstream_data;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        endcase

        data_d = OUT_WIDTH'(hold_d >> (32'(cnt_d) * OUT_WIDTH));
`ifdef STREAM_DOWNSIZER_LAST_EN
        last_d = (state_d == SEND) & (cnt_d == CNT_W'(LAST_CNT));
`endif
    end

    assign downstream_vld  = (state_q == SEND);
    assign downstream_data = data_q;
`ifdef STREAM_DOWNSIZER_LAST_EN
    assign downstream_last = last_q;
`endif

endmodule

// File: tb/tb_stream_downsizer.sv
// Scoreboard bench for stream_downsizer (32->8 instance plus an 8-bit RATIO=1 instance).
// Exercises downstream_last as well when STREAM_DOWNSIZER_LAST_EN is defined.
module tb_stream_downsizer;

    localparam int unsigned W  = 32;
    localparam int unsigned R  = 4;
    localparam int unsigned OW = W / R;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          upstream_vld;
    logic          upstream_rdy;
    logic [W-1:0]  upstream_data;
    logic          downstream_vld;
    logic          downstream_rdy;
    logic [OW-1:0] downstream_data;

    logic          r1_up_vld;
    logic          r1_up_rdy;
    logic [7:0]    r1_up_data;
    logic          r1_dn_vld;
    logic          r1_dn_rdy;
    logic [7:0]    r1_dn_data;
`ifdef STREAM_DOWNSIZER_LAST_EN
    logic          downstream_last;
    logic          r1_dn_last;
`endif

    int            total = 0;
    int            passed = 0;
    int            x_seen = 0;
    logic [OW-1:0] exp_q[$];
    bit            rand_on = 1'b0;

    always #5 clk = ~clk;

    stream_downsizer #(.IN_WIDTH(W), .RATIO(R)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .upstream_vld   (upstream_vld),
        .upstream_rdy   (upstream_rdy),
        .upstream_data  (upstream_data),
        .downstream_vld (downstream_vld),
        .downstream_rdy (downstream_rdy),
        .downstream_data(downstream_data)
`ifdef STREAM_DOWNSIZER_LAST_EN
        ,
        .downstream_last(downstream_last)
`endif
    );

    stream_downsizer #(.IN_WIDTH(8), .RATIO(1)) dut_r1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .upstream_vld   (r1_up_vld),
        .upstream_rdy   (r1_up_rdy),
        .upstream_data  (r1_up_data),
        .downstream_vld (r1_dn_vld),
        .downstream_rdy (r1_dn_rdy),
        .downstream_data(r1_dn_data)
`ifdef STREAM_DOWNSIZER_LAST_EN
        ,
        .downstream_last(r1_dn_last)
`endif
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Reference: beat i of a word is simply bits [8i+7:8i]
    function automatic logic [OW-1:0] slice(logic [W-1:0] w, int i);
        return OW'(w >> (OW * i));
    endfunction

    // Monitor: pop on every accepted beat, push RATIO expected beats on every accepted word
    always @(negedge clk) begin
        if (rst_n) begin
            if ($isunknown({downstream_vld, downstream_data, upstream_rdy})) x_seen++;
            if (downstream_vld && downstream_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL sb_unexpected_beat: got %0h, expected no beat at %0t",
                             downstream_data, $time);
                end else begin
                    check("sb_beat", 32'(downstream_data), 32'(exp_q.pop_front()));
                end
            end
            if (upstream_vld && upstream_rdy) begin
                for (int i = 0; i < int'(R); i++) exp_q.push_back(slice(upstream_data, i));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random downstream backpressure while the random phase runs
    initial begin
        forever begin
            tick();
            if (rand_on) downstream_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [W-1:0] w;
        bit           ok;
        rst_n = 1'b0; upstream_vld = 1'b0; upstream_data = '0; downstream_rdy = 1'b0;
        r1_up_vld = 1'b0; r1_up_data = '0; r1_dn_rdy = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("reset_vld", 32'(downstream_vld), 32'd0);
        check("reset_data", 32'(downstream_data), 32'd0);
        check("reset_up_rdy", 32'(upstream_rdy), 32'd1);
        tick();
        rst_n = 1'b1;

        // Single word, no backpressure
        downstream_rdy = 1'b1;
        w = 32'hDDCC_BBAA;
        upstream_vld = 1'b1; upstream_data = w;
        @(negedge clk);
        check("single_push_rdy", 32'(upstream_rdy), 32'd1);
        tick();
        upstream_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("single_vld", 32'(downstream_vld), 32'd1);
            check("single_data", 32'(downstream_data), 32'(slice(w, i)));
`ifdef STREAM_DOWNSIZER_LAST_EN
            check("single_last", 32'(downstream_last), 32'(i == 3));
`endif
        end
        @(negedge clk);
        check("single_idle", 32'(downstream_vld), 32'd0);

        // Back-to-back words, no bubble
        tick();
        upstream_vld = 1'b1; upstream_data = 32'h0302_0100;
        @(negedge clk);
        check("b2b_push0_rdy", 32'(upstream_rdy), 32'd1);
        tick();
        upstream_data = 32'h0706_0504;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b_vld", 32'(downstream_vld), 32'd1);
            check("b2b_data", 32'(downstream_data), i);
            check("b2b_up_rdy", 32'(upstream_rdy), 32'(i % 4 == 3));
`ifdef STREAM_DOWNSIZER_LAST_EN
            check("b2b_last", 32'(downstream_last), 32'(i % 4 == 3));
`endif
            if (i == 3) begin
                tick();
                upstream_vld = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle", 32'(downstream_vld), 32'd0);

        // Backpressure on beat 2
        tick();
        upstream_vld = 1'b1; upstream_data = 32'hDDCC_BBAA;
        @(negedge clk);
        tick();
        upstream_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tick();
        downstream_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_vld", 32'(downstream_vld), 32'd1);
            check("bp_data", 32'(downstream_data), 32'h0000_00CC);
            check("bp_up_rdy", 32'(upstream_rdy), 32'd0);
        end
        tick();
        downstream_rdy = 1'b1;
        @(negedge clk);
        check("bp_resume_cc", 32'(downstream_data), 32'h0000_00CC);
        @(negedge clk);
        check("bp_resume_dd", 32'(downstream_data), 32'h0000_00DD);
        @(negedge clk);
        check("bp_idle", 32'(downstream_vld), 32'd0);

        // Reset in the middle of a word
        tick();
        upstream_vld = 1'b1; upstream_data = 32'h4433_2211;
        @(negedge clk);
        tick();
        upstream_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_vld", 32'(downstream_vld), 32'd0);
        check("midrst_up_rdy", 32'(upstream_rdy), 32'd1);
        check("midrst_data", 32'(downstream_data), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst_no_beat", 32'(downstream_vld), 32'd0);
        end

        // RATIO=1 instance acts as a one-deep register stage
        tick();
        r1_up_vld = 1'b1; r1_up_data = 8'h5A;
        @(negedge clk);
        check("r1_push_rdy", 32'(r1_up_rdy), 32'd1);
        tick();
        r1_up_vld = 1'b0; r1_dn_rdy = 1'b0;
        @(negedge clk);
        check("r1_vld", 32'(r1_dn_vld), 32'd1);
        check("r1_data", 32'(r1_dn_data), 32'h5A);
        check("r1_full_rdy", 32'(r1_up_rdy), 32'd0);
`ifdef STREAM_DOWNSIZER_LAST_EN
        check("r1_last", 32'(r1_dn_last), 32'd1);
`endif
        tick();
        r1_dn_rdy = 1'b1;
        @(negedge clk);
        check("r1_pass_rdy", 32'(r1_up_rdy), 32'd1);
        @(negedge clk);
        check("r1_idle", 32'(r1_dn_vld), 32'd0);

        // Random valid/ready traffic, 1000 words
        tick();
        rand_on = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            upstream_vld = 1'b1;
            upstream_data = $urandom;
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                ok = upstream_rdy;
            end
            if (!ok) begin
                total++;
                $display("FAIL rand_push_timeout: got no upstream_rdy, expected one within 200 cycles");
            end
            tick();
            upstream_vld = 1'b0;
        end
        rand_on = 1'b0;
        downstream_rdy = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_idle", 32'(downstream_vld), 32'd0);
        check("no_x_outputs", 32'(x_seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
